sram_address_calculator: RTL and testbench
==========================================

Name: sram_address_calculator

Overview:
- Generates the 26-bit SRAM word address for the convolution datapath.
- Keeps two independent offset counters:
  - row-cache offset, used for SDRAM->SRAM fills and SRAM->window-buffer reads;
  - output offset, used for window-buffer->SRAM writes and SRAM->SDRAM drains.
- `mode` selects which region is addressed and which counter advances.
- Each counter wraps automatically at the end of its image row.

Parameters:
- ADDR_W, 26, SRAM address width
- WIDTH_W, 13, image-width and offset-counter width

Ports:
- clk  in  1  system clock, rising-edge active
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear of both offset counters
- mode  in  1  1 = row-cache region (read side), 0 = output region (write side)
- enable  in  1  advance the counter selected by mode by one this cycle
- image_width  in  13  pixels per row; held stable during a row
- sram_rowCacheStart  in  26  base address of the row cache
- sram_outputAddrStart  in  26  base address of the output row
- sram_addr  out  26  current SRAM address

Behaviour:
- State: row_off[12:0] and out_off[12:0], both registered.
- Reset (n_rst=0, asynchronous): row_off=0, out_off=0.
  - During reset, sram_addr still follows mode, so it equals the selected start address.
- Output is combinational from mode and the registered offsets:
  - mode=1: sram_addr = sram_rowCacheStart + row_off;
  - mode=0: sram_addr = sram_outputAddrStart + out_off.
  - Addition is modulo 2^26, with the offset zero-extended.
  - A change of mode or of a base input is reflected in the same cycle.
- Row-cache limit = image_width.
  - On a rising edge with enable=1, mode=1, clear=0: row_off <= (row_off+1 >= image_width) ? 0 : row_off+1.
- Output limit = image_width-1, because the output row is one element shorter.
  - On a rising edge with enable=1, mode=0, clear=0: out_off <= (out_off+1 >= image_width-1) ? 0 : out_off+1.
  - Compare with at least 14-bit unsigned arithmetic so the limit does not underflow.
- The unselected counter holds its value; enable=0 holds both counters.
- clear=1 on a rising edge: both offsets go to 0. clear has priority over enable.
- Wrap examples:
  - image_width=1: row_off stays 0. image_width=0: row_off stays 0.
  - image_width<=2: out_off stays 0.
- image_width changing mid-row: the new limit applies from the next increment.
  - If the offset already exceeds the new limit, the next increment wraps to 0.
- Latency: an increment is visible on sram_addr one clock after the enable edge.
- No handshake: the caller asserts enable once per access.

Decomposition:
- Shared package:
  - ADDR_W and WIDTH_W constants;
  - typedef sram_addr_t (logic [25:0]);
  - typedef px_count_t (logic [12:0]).
- One natural sub-module, wrap_offset_counter, instantiated twice:
  - ports: clk, n_rst, clear, inc, limit -> count;
  - behaviour: wraps to 0 when count+1 >= limit.
- Top-level contents: the two instances, the limit computation and the output mux/adder.

Test Plan:
- Reset: n_rst=0 with rowCacheStart=440, outputAddrStart=4400.
  - mode=1 -> sram_addr=440; mode=0 -> sram_addr=4400, both while still in reset.
- Row sweep: image_width=50, mode=1, 50 single-cycle enable pulses.
  - After pulse k (1..49): sram_addr=440+k, and mode=0 shows 4400.
  - After pulse 50: sram_addr=440 (wrap).
- Output sweep: mode=0, 49 enable pulses.
  - After pulse k (1..48): sram_addr=4400+k, and mode=1 shows 440.
  - After pulse 49: sram_addr=4400.
- Clear:
  - Advance row_off to 10 and out_off to 10.
  - Pulse clear with enable=1 -> mode=1 gives 440, mode=0 gives 4400.
- Edge widths:
  - image_width=1 with repeated mode=1 enables -> sram_addr stays 440.
  - image_width=2 with mode=0 enables -> sram_addr stays 4400.
- Async reset mid-sweep: assert n_rst low between clock edges with row_off=7 -> sram_addr immediately returns to 440 (mode=1).

Source files
------------

// File: rtl/sram_address_calculator_pkg.sv
// Shared types and widths for the SRAM address calculator.
// Exports ADDR_W, WIDTH_W, sram_addr_t, px_count_t, limit_t.
package sram_address_calculator_pkg;

   localparam int ADDR_W  = 26;
   localparam int WIDTH_W = 13;

   typedef logic [ADDR_W-1:0]  sram_addr_t;
   typedef logic [WIDTH_W-1:0] px_count_t;
   // One bit wider than a pixel count so wrap compares never overflow.
   typedef logic [WIDTH_W:0]   limit_t;

endpackage

// File: rtl/sram_address_calculator_wrap.sv
// Offset counter that wraps to zero when count+1 reaches limit.
// Ports: clk, n_rst, clear, inc, limit (14b) -> count (13b).
module wrap_offset_counter
   import sram_address_calculator_pkg::*;
(
   input  logic      clk,
   input  logic      n_rst,
   input  logic      clear,
   input  logic      inc,
   input  limit_t    limit,
   output px_count_t count
);

   px_count_t count_q;
   px_count_t count_d;
   limit_t    count_p1;

   assign count_p1 = {1'b0, count_q} + limit_t'(1);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         if (count_p1 >= limit) begin
            count_d = '0;
         end else begin
            count_d = count_p1[WIDTH_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/sram_address_calculator.sv
// SRAM word address generator: row-cache and output offset counters.
// Ports: clk, n_rst, clear, mode, enable, image_width, bases -> sram_addr.
module sram_address_calculator
   import sram_address_calculator_pkg::*;
(
   input  logic                clk,
   input  logic                n_rst,
   input  logic                clear,
   input  logic                mode,
   input  logic                enable,
   input  logic [WIDTH_W-1:0]  image_width,
   input  logic [ADDR_W-1:0]   sram_rowCacheStart,
   input  logic [ADDR_W-1:0]   sram_outputAddrStart,
   output logic [ADDR_W-1:0]   sram_addr
);

   limit_t    row_limit;
   limit_t    out_limit;
   px_count_t row_off;
   px_count_t out_off;
   logic      row_inc;
   logic      out_inc;

   assign row_limit = {1'b0, image_width};

   // Output row is one element shorter. A zero width maps to a zero
   // limit so the counter simply stays at 0 instead of underflowing.
   always_comb begin
      out_limit = '0;
      if (image_width != '0) begin
         out_limit = {1'b0, image_width} - limit_t'(1);
      end
   end

   assign row_inc = enable &  mode;
   assign out_inc = enable & ~mode;

   wrap_offset_counter u_row_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (clear),
      .inc   (row_inc),
      .limit (row_limit),
      .count (row_off)
   );

   wrap_offset_counter u_out_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (clear),
      .inc   (out_inc),
      .limit (out_limit),
      .count (out_off)
   );

   always_comb begin
      if (mode) begin
         sram_addr = sram_rowCacheStart
                   + {{(ADDR_W-WIDTH_W){1'b0}}, row_off};
      end else begin
         sram_addr = sram_outputAddrStart
                   + {{(ADDR_W-WIDTH_W){1'b0}}, out_off};
      end
   end

endmodule

// File: tb/tb_sram_address_calculator.sv
// Self-checking bench for sram_address_calculator.
// Expected addresses queue up at stimulus time and pop at sampling.
module tb_sram_address_calculator;

   logic        clk;
   logic        n_rst;
   logic        clear;
   logic        mode;
   logic        enable;
   logic [12:0] image_width;
   logic [25:0] row_base;
   logic [25:0] out_base;
   logic [25:0] sram_addr;

   int n_chk;
   int n_fail;
   logic [25:0] sb[$];

   sram_address_calculator dut (
      .clk                  (clk),
      .n_rst                (n_rst),
      .clear                (clear),
      .mode                 (mode),
      .enable               (enable),
      .image_width          (image_width),
      .sram_rowCacheStart   (row_base),
      .sram_outputAddrStart (out_base),
      .sram_addr            (sram_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [25:0] got,
                      input logic [25:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one enable edge in the given mode, optional clear.
   task automatic pulse(input logic m, input logic c);
      @(negedge clk);
      mode   = m;
      enable = 1'b1;
      clear  = c;
      @(posedge clk);
      #1;
      enable = 1'b0;
      clear  = 1'b0;
   endtask

   // Queue an expectation for mode m, then sample and compare.
   task automatic look(input string tag,
                       input logic m,
                       input logic [25:0] exp);
      logic [25:0] e;
      mode = m;
      sb.push_back(exp);
      #1;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         chk(tag, sram_addr, e);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      n_rst       = 1'b1;
      clear       = 1'b0;
      mode        = 1'b1;
      enable      = 1'b0;
      image_width = 13'd50;
      row_base    = 26'd440;
      out_base    = 26'd4400;
      #1 n_rst = 1'b0;
      #1;
      look("rst_mode1", 1'b1, 26'd440);
      look("rst_mode0", 1'b0, 26'd4400);
      @(negedge clk);
      n_rst = 1'b1;

      // Row-cache sweep across one 50-pixel row.
      for (int k = 1; k <= 50; k++) begin
         pulse(1'b1, 1'b0);
         if (k == 50) begin
            look("row_wrap", 1'b1, 26'd440);
         end else begin
            look("row_sweep", 1'b1, 26'(440 + k));
            look("row_out_hold", 1'b0, 26'd4400);
         end
      end

      // Output sweep, one element shorter.
      for (int k = 1; k <= 49; k++) begin
         pulse(1'b0, 1'b0);
         if (k == 49) begin
            look("out_wrap", 1'b0, 26'd4400);
         end else begin
            look("out_sweep", 1'b0, 26'(4400 + k));
            look("out_row_hold", 1'b1, 26'd440);
         end
      end

      // Clear beats enable.
      for (int k = 0; k < 10; k++) begin
         pulse(1'b1, 1'b0);
         pulse(1'b0, 1'b0);
      end
      look("pre_clr_row", 1'b1, 26'd450);
      look("pre_clr_out", 1'b0, 26'd4410);
      pulse(1'b1, 1'b1);
      look("clr_row", 1'b1, 26'd440);
      look("clr_out", 1'b0, 26'd4400);

      // Degenerate widths.
      image_width = 13'd1;
      for (int k = 0; k < 4; k++) begin
         pulse(1'b1, 1'b0);
         look("w1_row", 1'b1, 26'd440);
      end
      image_width = 13'd2;
      for (int k = 0; k < 4; k++) begin
         pulse(1'b0, 1'b0);
         look("w2_out", 1'b0, 26'd4400);
      end
      image_width = 13'd0;
      for (int k = 0; k < 3; k++) begin
         pulse(1'b1, 1'b0);
         look("w0_row", 1'b1, 26'd440);
         pulse(1'b0, 1'b0);
         look("w0_out", 1'b0, 26'd4400);
      end

      // Shrinking width mid-row wraps on the next increment.
      image_width = 13'd50;
      for (int k = 0; k < 7; k++) pulse(1'b1, 1'b0);
      look("row_at7", 1'b1, 26'd447);
      image_width = 13'd4;
      pulse(1'b1, 1'b0);
      look("shrink_wrap", 1'b1, 26'd440);

      // Base change shows up combinationally.
      row_base = 26'h3FF_FFFF;
      pulse(1'b1, 1'b0);
      look("base_mod", 1'b1, 26'd0);
      row_base = 26'd440;
      look("base_back", 1'b1, 26'd441);

      // Asynchronous reset between edges.
      image_width = 13'd50;
      clear = 1'b1;
      pulse(1'b1, 1'b1);
      for (int k = 0; k < 7; k++) pulse(1'b1, 1'b0);
      look("pre_arst", 1'b1, 26'd447);
      n_rst = 1'b0;
      look("arst_row", 1'b1, 26'd440);
      @(negedge clk);
      n_rst = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
